countdown_timer: RTL and testbench

- Loadable down-counter: the decrementing counterpart to the free-running up-counter benchmark.
- Accepts a start value over a valid/ready handshake, counts down to zero one step per enabled cycle, then emits a one-cycle done pulse.
- Serves as a small model-checking benchmark with both safety and liveness obligations, and as a reusable timeout primitive.

---
 rtl/countdown_timer.sv | 117 +++++++++++
 tb/tb_countdown_timer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with valid/ready load and done pulse.
// Define FORMAL_PROPS_EN to embed safety/liveness properties.
module countdown_timer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [W-1:0] load_value,
  input  logic         pause,
  input  logic         abort,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_count;
  logic [W-1:0]   w_count_nxt;
  logic           w_hs;
  logic           w_last;

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  assign w_hs   = load_valid && (r_state == S_IDLE);
  assign w_last = (r_count == ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    unique case (r_state)
      S_IDLE: begin
        if (w_hs) begin
          w_count_nxt = load_value;
          if (load_value != '0) begin
            w_state_nxt = S_RUN;
          end else begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (!pause) begin
          // RUN always holds count >= 1, so no underflow path
          w_count_nxt = r_count - ONE;
          if (w_last) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  assign load_ready = (r_state == S_IDLE);
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);
  assign count      = r_count;

`ifdef FORMAL_PROPS_EN
  logic [W-1:0] r_shadow;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shadow <= '0;
    end else if (w_hs) begin
      r_shadow <= load_value;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_done_zero: assert (!done || count == '0);
      a_excl: assert (!(busy && done));
      a_bound: assert (!busy || count <= r_shadow);
      a_ready: assert (!load_ready || !busy);
    end
  end

  m_env: assume property (
    @(posedge clk) !rst && !pause && !abort
  );

  a_live: assert property (
    @(posedge clk) busy |-> s_eventually done
  );
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: W=10 main instance, W=3 edge instance.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_lv = 1'b0;
  logic       a_lr;
  logic [9:0] a_val = '0;
  logic       a_pause = 1'b0;
  logic       a_abort = 1'b0;
  logic [9:0] a_cnt;
  logic       a_busy;
  logic       a_done;

  logic       b_lv = 1'b0;
  logic       b_lr;
  logic [2:0] b_val = '0;
  logic       b_pause = 1'b0;
  logic       b_abort = 1'b0;
  logic [2:0] b_cnt;
  logic       b_busy;
  logic       b_done;

  int nvec = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  countdown_timer #(.W(10)) u_a (
    .clk(clk), .rst(rst),
    .load_valid(a_lv), .load_ready(a_lr),
    .load_value(a_val),
    .pause(a_pause), .abort(a_abort),
    .count(a_cnt), .busy(a_busy), .done(a_done)
  );

  countdown_timer #(.W(3)) u_b (
    .clk(clk), .rst(rst),
    .load_valid(b_lv), .load_ready(b_lr),
    .load_value(b_val),
    .pause(b_pause), .abort(b_abort),
    .count(b_cnt), .busy(b_busy), .done(b_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ck(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic ck_a(
    input string       tag,
    input logic        lr,
    input logic        bs,
    input logic        dn,
    input logic [9:0]  c
  );
    ck({tag, ".ready"}, 32'(a_lr), 32'(lr));
    ck({tag, ".busy"}, 32'(a_busy), 32'(bs));
    ck({tag, ".done"}, 32'(a_done), 32'(dn));
    ck({tag, ".count"}, 32'(a_cnt), 32'(c));
  endtask

  task automatic ck_b(
    input string       tag,
    input logic        lr,
    input logic        bs,
    input logic        dn,
    input logic [2:0]  c
  );
    ck({tag, ".ready"}, 32'(b_lr), 32'(lr));
    ck({tag, ".busy"}, 32'(b_busy), 32'(bs));
    ck({tag, ".done"}, 32'(b_done), 32'(dn));
    ck({tag, ".count"}, 32'(b_cnt), 32'(c));
  endtask

  initial begin
    // reset held for two edges
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ck_a("rst", 1, 0, 0, 0);
    ck_b("rst_b", 1, 0, 0, 0);

    // load 5: counts 5..1, done after edge t0+5
    a_val = 10'd5;
    a_lv = 1'b1;
    step();
    a_lv = 1'b0;
    for (int i = 5; i >= 1; i--) begin
      ck_a($sformatf("ld5_%0d", i), 0, 1, 0, 10'(i));
      step();
    end
    ck_a("ld5_done", 0, 0, 1, 0);
    step();
    ck_a("ld5_idle", 1, 0, 0, 0);

    // load 0: straight to DONE
    a_val = 10'd0;
    a_lv = 1'b1;
    step();
    a_lv = 1'b0;
    ck_a("ld0_done", 0, 0, 1, 0);
    step();
    ck_a("ld0_idle", 1, 0, 0, 0);

    // load 4 with 3 paused cycles after first decrement
    a_val = 10'd4;
    a_lv = 1'b1;
    step();
    a_lv = 1'b0;
    ck_a("p_4", 0, 1, 0, 4);
    step();
    ck_a("p_3", 0, 1, 0, 3);
    a_pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      ck_a($sformatf("p_hold%0d", i), 0, 1, 0, 3);
    end
    a_pause = 1'b0;
    step();
    ck_a("p_2", 0, 1, 0, 2);
    step();
    ck_a("p_1", 0, 1, 0, 1);
    step();
    ck_a("p_done", 0, 0, 1, 0);
    step();
    ck_a("p_idle", 1, 0, 0, 0);

    // load 6, abort at count 2
    a_val = 10'd6;
    a_lv = 1'b1;
    step();
    a_lv = 1'b0;
    for (int i = 6; i > 2; i--) step();
    ck_a("ab_2", 0, 1, 0, 2);
    a_abort = 1'b1;
    step();
    a_abort = 1'b0;
    ck_a("ab_idle", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      ck_a($sformatf("ab_quiet%0d", i), 1, 0, 0, 0);
    end

    // same scenario using reset
    a_val = 10'd6;
    a_lv = 1'b1;
    step();
    a_lv = 1'b0;
    for (int i = 6; i > 2; i--) step();
    ck_a("rs_2", 0, 1, 0, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    ck_a("rs_idle", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      ck_a($sformatf("rs_quiet%0d", i), 1, 0, 0, 0);
    end

    // ignored pause/abort in IDLE, value holds at 0
    a_pause = 1'b1;
    a_abort = 1'b1;
    step();
    ck_a("idle_ign", 1, 0, 0, 0);
    a_pause = 1'b0;
    a_abort = 1'b0;

    // W=3: max load 7, load_valid held high throughout
    b_val = 3'd7;
    b_lv = 1'b1;
    step();
    for (int i = 7; i >= 1; i--) begin
      ck_b($sformatf("w3_%0d", i), 0, 1, 0, 3'(i));
      step();
    end
    ck_b("w3_done", 0, 0, 1, 0);
    step();
    ck_b("w3_idle", 1, 0, 0, 0);
    step();
    ck_b("w3_reload", 0, 1, 0, 7);
    b_lv = 1'b0;
    step();
    ck_b("w3_dec", 0, 1, 0, 6);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nfail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim did not finish");
    $fatal(1, "timeout");
  end

endmodule
